// File: rtl/cajero_automatico_pkg.sv
// Shared types and constants for the ATM transaction controller.
package cajero_automatico_pkg;

    typedef enum logic [2:0] {
        ESPERA_TARJETA,
        INGRESO_PIN,
        ESPERA_MONTO,
        FIN,
        BLOQUEADO
    } estado_t;

    localparam int unsigned PIN_DIGITOS   = 4;
    localparam int unsigned ANCHO_DIGITO  = 4;
    localparam int unsigned ANCHO_PIN     = ANCHO_DIGITO * PIN_DIGITOS;
    localparam logic        TIPO_DEPOSITO = 1'b0;
    localparam logic        TIPO_RETIRO   = 1'b1;

endpackage

// File: rtl/cajero_automatico_verificador_pin.sv
// PIN collector: shifts in BCD digits and compares the full PIN on the last one.
module verificador_pin
    import cajero_automatico_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    limpiar,
    input  logic                    digito_stb,
    input  logic [ANCHO_DIGITO-1:0] digito,
    input  logic [ANCHO_PIN-1:0]    pin,
    output logic                    pin_listo,
    output logic                    pin_ok
);

    localparam int unsigned ANCHO_CUENTA = $clog2(PIN_DIGITOS);
    localparam int unsigned ANCHO_REG    = ANCHO_PIN - ANCHO_DIGITO;

    // Only the earlier digits are stored; the last one is compared straight
    // from the input so the result is available in the strobe cycle.
    logic [ANCHO_REG-1:0]    registro;
    logic [ANCHO_CUENTA-1:0] cuenta;
    logic                    ultimo;
    logic [ANCHO_PIN-1:0]    ensamblado;

    assign ultimo     = (cuenta == ANCHO_CUENTA'(PIN_DIGITOS - 1));
    assign ensamblado = {registro, digito};
    assign pin_listo  = digito_stb && ultimo && !limpiar;
    assign pin_ok     = pin_listo && (ensamblado == pin);

    // Digit shift register and position counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            registro <= '0;
            cuenta   <= '0;
        end else if (limpiar) begin
            cuenta <= '0;
        end else if (digito_stb) begin
            registro <= {registro[ANCHO_REG-ANCHO_DIGITO-1:0], digito};
            cuenta   <= ultimo ? '0 : cuenta + 1'b1;
        end
    end

endmodule

// File: rtl/cajero_automatico.sv
// ATM controller: card acceptance, PIN check with lock-out, one deposit or withdrawal.
module cajero_automatico
    import cajero_automatico_pkg::*;
#(
    parameter int unsigned MAX_INTENTOS        = 3,
    parameter int unsigned INTENTO_ADVERTENCIA = 2,
    parameter int unsigned ANCHO_BALANCE       = 64,
    parameter int unsigned ANCHO_MONTO         = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     tarjeta_recibida,
    input  logic                     tipo_trans,
    input  logic                     digito_stb,
    input  logic [ANCHO_DIGITO-1:0]  digito,
    input  logic [ANCHO_PIN-1:0]     pin,
    input  logic [ANCHO_BALANCE-1:0] balance_inicial,
    input  logic [ANCHO_MONTO-1:0]   monto,
    input  logic                     monto_stb,
    output logic [ANCHO_BALANCE-1:0] balance,
    output logic                     balance_actualizado,
    output logic                     entregar_dinero,
    output logic                     pin_incorrecto,
    output logic                     advertencia,
    output logic                     bloqueo,
    output logic                     fondos_insuficientes
);

    localparam int unsigned ANCHO_INT = $clog2(MAX_INTENTOS + 1);

    estado_t                  estado, estado_sig;
    logic [ANCHO_INT-1:0]     intentos, intentos_sig;
    logic [ANCHO_BALANCE-1:0] monto_ext;
    logic                     stb_pin, stb_monto, limpiar;
    logic                     pin_listo, pin_ok;

    // Card removal wins over any coincident strobe.
    assign stb_pin      = digito_stb && tarjeta_recibida && (estado == INGRESO_PIN);
    assign stb_monto    = monto_stb && tarjeta_recibida && (estado == ESPERA_MONTO);
    assign limpiar      = (estado == ESPERA_TARJETA) ||
                          ((estado == INGRESO_PIN) && !tarjeta_recibida);
    assign intentos_sig = intentos + 1'b1;
    assign monto_ext    = ANCHO_BALANCE'(monto);

    verificador_pin u_verificador (
        .clock      (clock),
        .reset      (reset),
        .limpiar    (limpiar),
        .digito_stb (stb_pin),
        .digito     (digito),
        .pin        (pin),
        .pin_listo  (pin_listo),
        .pin_ok     (pin_ok)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) estado <= ESPERA_TARJETA;
        else       estado <= estado_sig;
    end

    // Next-state logic.
    always_comb begin
        estado_sig = estado;
        unique case (estado)
            ESPERA_TARJETA: if (tarjeta_recibida) estado_sig = INGRESO_PIN;
            INGRESO_PIN: begin
                if (!tarjeta_recibida)
                    estado_sig = ESPERA_TARJETA;
                else if (pin_ok)
                    estado_sig = ESPERA_MONTO;
                else if (pin_listo && intentos_sig == ANCHO_INT'(MAX_INTENTOS))
                    estado_sig = BLOQUEADO;
            end
            ESPERA_MONTO: begin
                if (!tarjeta_recibida) estado_sig = ESPERA_TARJETA;
                else if (stb_monto)    estado_sig = FIN;
            end
            FIN:       if (!tarjeta_recibida) estado_sig = ESPERA_TARJETA;
            BLOQUEADO: estado_sig = BLOQUEADO;
            default:   estado_sig = ESPERA_TARJETA;
        endcase
    end

    // Registered outputs: balance, attempt counter and status flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            balance              <= '0;
            intentos             <= '0;
            balance_actualizado  <= 1'b0;
            entregar_dinero      <= 1'b0;
            pin_incorrecto       <= 1'b0;
            advertencia          <= 1'b0;
            bloqueo              <= 1'b0;
            fondos_insuficientes <= 1'b0;
        end else begin
            balance_actualizado  <= 1'b0;
            entregar_dinero      <= 1'b0;
            pin_incorrecto       <= 1'b0;
            fondos_insuficientes <= 1'b0;
            if (estado == ESPERA_TARJETA && tarjeta_recibida) begin
                balance <= balance_inicial;
            end
            if (pin_ok) begin
                intentos    <= '0;
                advertencia <= 1'b0;
            end else if (pin_listo) begin
                pin_incorrecto <= 1'b1;
                intentos       <= intentos_sig;
                if (intentos_sig == ANCHO_INT'(INTENTO_ADVERTENCIA)) advertencia <= 1'b1;
                if (intentos_sig == ANCHO_INT'(MAX_INTENTOS))        bloqueo     <= 1'b1;
            end
            if (stb_monto) begin
                if (tipo_trans == TIPO_DEPOSITO) begin
                    balance             <= balance + monto_ext;
                    balance_actualizado <= 1'b1;
                end else if (monto_ext <= balance) begin
                    balance             <= balance - monto_ext;
                    balance_actualizado <= 1'b1;
                    entregar_dinero     <= 1'b1;
                end else begin
                    fondos_insuficientes <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cajero_automatico.sv
// Scoreboard bench for the ATM controller: expected events queued at stimulus time.
module tb_cajero_automatico;
    import cajero_automatico_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        tarjeta_recibida = 1'b0;
    logic        tipo_trans = 1'b0;
    logic        digito_stb = 1'b0;
    logic [3:0]  digito = '0;
    logic [15:0] pin = '0;
    logic [63:0] balance_inicial = '0;
    logic [31:0] monto = '0;
    logic        monto_stb = 1'b0;
    logic [63:0] balance;
    logic        balance_actualizado, entregar_dinero, pin_incorrecto;
    logic        advertencia, bloqueo, fondos_insuficientes;

    cajero_automatico #(
        .MAX_INTENTOS        (3),
        .INTENTO_ADVERTENCIA (2),
        .ANCHO_BALANCE       (64),
        .ANCHO_MONTO         (32)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .tarjeta_recibida     (tarjeta_recibida),
        .tipo_trans           (tipo_trans),
        .digito_stb           (digito_stb),
        .digito               (digito),
        .pin                  (pin),
        .balance_inicial      (balance_inicial),
        .monto                (monto),
        .monto_stb            (monto_stb),
        .balance              (balance),
        .balance_actualizado  (balance_actualizado),
        .entregar_dinero      (entregar_dinero),
        .pin_incorrecto       (pin_incorrecto),
        .advertencia          (advertencia),
        .bloqueo              (bloqueo),
        .fondos_insuficientes (fondos_insuficientes)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] bal;
        logic act, ent, pinc, fon, adv, bloq;
    } evento_t;

    evento_t sb[$];
    int unsigned total = 0;
    int unsigned bad   = 0;

    // Reference model state.
    logic [63:0] m_bal;
    logic [15:0] m_pin;
    int unsigned m_int;
    logic        m_adv, m_bloq;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void push(input logic act, input logic ent, input logic pinc, input logic fon);
        evento_t e;
        e.bal = m_bal; e.act = act; e.ent = ent; e.pinc = pinc; e.fon = fon;
        e.adv = m_adv; e.bloq = m_bloq;
        sb.push_back(e);
    endfunction

    // Any result pulse must match the oldest expected event.
    always @(negedge clock) begin
        if (!reset && (balance_actualizado || entregar_dinero || pin_incorrecto || fondos_insuficientes)) begin
            if (sb.size() == 0) begin
                check("spurious_pulse",
                      {60'd0, balance_actualizado, entregar_dinero, pin_incorrecto, fondos_insuficientes}, 64'd0);
            end else begin
                evento_t e;
                e = sb.pop_front();
                check("ev_balance", balance, e.bal);
                check("ev_actualizado", 64'(balance_actualizado), 64'(e.act));
                check("ev_entregar", 64'(entregar_dinero), 64'(e.ent));
                check("ev_pin_incorrecto", 64'(pin_incorrecto), 64'(e.pinc));
                check("ev_fondos", 64'(fondos_insuficientes), 64'(e.fon));
                check("ev_advertencia", 64'(advertencia), 64'(e.adv));
                check("ev_bloqueo", 64'(bloqueo), 64'(e.bloq));
            end
        end
    end

    task automatic apply_reset();
        tarjeta_recibida = 1'b0; digito_stb = 1'b0; monto_stb = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_balance", balance, 64'd0);
        check("rst_flags", {58'd0, balance_actualizado, entregar_dinero, pin_incorrecto,
                            advertencia, bloqueo, fondos_insuficientes}, 64'd0);
        sb.delete();
        m_bal = '0; m_int = 0; m_adv = 1'b0; m_bloq = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic insert_card(input logic [63:0] bal, input logic [15:0] p);
        pin = p; m_pin = p;
        balance_inicial = bal; m_bal = bal;
        tarjeta_recibida = 1'b1;
        @(negedge clock);
        #1 check("card_balance", balance, bal);
    endtask

    task automatic remove_card();
        tarjeta_recibida = 1'b0;
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic enter_pin(input logic [15:0] v);
        for (int i = 0; i < 4; i++) begin
            if (i == 3 && !m_bloq) begin
                if (v == m_pin) begin
                    m_int = 0; m_adv = 1'b0;
                end else begin
                    m_int++;
                    if (m_int == 2) m_adv = 1'b1;
                    if (m_int == 3) m_bloq = 1'b1;
                    push(1'b0, 1'b0, 1'b1, 1'b0);
                end
            end
            digito = v[15-4*i -: 4];
            digito_stb = 1'b1;
            @(negedge clock);
            digito_stb = 1'b0;
        end
        #1;
        check("pin_lost_event", 64'(sb.size()), 64'd0);
        check("pin_advertencia", 64'(advertencia), 64'(m_adv));
        check("pin_bloqueo", 64'(bloqueo), 64'(m_bloq));
    endtask

    // expect_event=0 models a strobe that must be ignored.
    task automatic transaction(input logic tipo, input logic [31:0] m, input bit expect_event);
        if (expect_event) begin
            if (tipo == TIPO_DEPOSITO) begin
                m_bal = m_bal + 64'(m);
                push(1'b1, 1'b0, 1'b0, 1'b0);
            end else if (64'(m) <= m_bal) begin
                m_bal = m_bal - 64'(m);
                push(1'b1, 1'b1, 1'b0, 1'b0);
            end else begin
                push(1'b0, 1'b0, 1'b0, 1'b1);
            end
        end
        tipo_trans = tipo; monto = m;
        monto_stb = 1'b1;
        @(negedge clock);
        monto_stb = 1'b0;
        @(negedge clock);
        #1;
        check("trans_lost_event", 64'(sb.size()), 64'd0);
        check("trans_balance", balance, m_bal);
    endtask

    initial begin
        m_pin = '0;
        apply_reset();

        // Asynchronous reset in the middle of PIN entry.
        insert_card(64'd777, 16'h1234);
        digito = 4'd1; digito_stb = 1'b1; @(negedge clock);
        digito = 4'd2; @(negedge clock); digito_stb = 1'b0;
        apply_reset();

        // Correct PIN and deposit; a second strobe in FIN is ignored.
        insert_card(64'd1000, 16'h1234);
        enter_pin(16'h1234);
        transaction(TIPO_DEPOSITO, 32'd500, 1'b1);
        transaction(TIPO_DEPOSITO, 32'd7, 1'b0);
        remove_card();

        // Exact withdrawal, then refused withdrawal.
        insert_card(64'd300, 16'h4321);
        enter_pin(16'h4321);
        transaction(TIPO_RETIRO, 32'd300, 1'b1);
        remove_card();
        insert_card(64'd300, 16'h4321);
        enter_pin(16'h4321);
        transaction(TIPO_RETIRO, 32'd301, 1'b1);
        remove_card();

        // Lock-out after three wrong PINs; the correct PIN is then ignored.
        insert_card(64'd50, 16'h1234);
        enter_pin(16'h1111);
        enter_pin(16'h1111);
        enter_pin(16'h1111);
        enter_pin(16'h1234);
        transaction(TIPO_DEPOSITO, 32'd9, 1'b0);
        apply_reset();

        // Attempt counter survives card removal.
        insert_card(64'd10, 16'h9876);
        enter_pin(16'h0000);
        enter_pin(16'h9870);
        remove_card();
        insert_card(64'd10, 16'h9876);
        enter_pin(16'h9875);
        apply_reset();

        // Ignored amount strobe during PIN entry, then wrapping deposit.
        insert_card(64'hFFFF_FFFF_FFFF_FFFF, 16'h5A09);
        transaction(TIPO_DEPOSITO, 32'd3, 1'b0);
        enter_pin(16'h5A09);
        transaction(TIPO_DEPOSITO, 32'd1, 1'b1);
        remove_card();

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
